regfile_mp: RTL

- Parametrised multi-port register file for the pipelined ARM core; next generation of the single-write, two-read register file.
- Adds a configurable read-port count, two write ports (ALU/load result plus base-register writeback), same-cycle write-to-read bypass, and reset clearing.
- Adds a per-register pending scoreboard, so decode can detect RAW hazards without an external hazard table.
- Sits between decode (reads, issue) and writeback (writes); the PC register is supplied externally.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_if.sv | 32 +++
 rtl/regfile_sb.sv | 43 ++++
 rtl/regfile_mp.sv | 74 +++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// the PC index helper and the writeback port record.
package regfile_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int NREGS_DEF = 16;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  // The top index is the PC, which is owned by fetch and never stored here.
  function automatic int PC_IDX(input int nregs);
    return nregs - 1;
  endfunction

  typedef struct packed {
    logic                 we;
    logic [AW_DEF-1:0]    wa;
    logic [WIDTH_DEF-1:0] wd;
  } wport_t;

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback-facing bus of the register file. The master side
// (the pipeline) drives the addresses, writes and issue; the slave side
// (the register file) returns the read data and hazard status.
interface regfile_if #(
  parameter  int WIDTH = 32,
  parameter  int NREGS = 16,
  parameter  int NRD   = 3,
  localparam int AW    = $clog2(NREGS)
);

  logic [NRD-1:0][AW-1:0]    ra;
  logic [NRD-1:0][WIDTH-1:0] rd;
  logic [NRD-1:0]            busy;
  logic [1:0]                we;
  logic [1:0][AW-1:0]        wa;
  logic [1:0][WIDTH-1:0]     wd;
  logic [WIDTH-1:0]          pc;
  logic                      issue_valid;
  logic [AW-1:0]             issue_addr;
  logic [NREGS-1:0]          pending;

  modport master (
    output ra, we, wa, wd, pc, issue_valid, issue_addr,
    input  rd, busy, pending
  );

  modport slave (
    input  ra, we, wa, wd, pc, issue_valid, issue_addr,
    output rd, busy, pending
  );

endinterface

// File: rtl/regfile_sb.sv
// Register scoreboard: one pending bit per architectural register, set at
// issue and cleared at writeback, plus the per-read-port busy lookup.
module regfile_sb #(
  parameter  int NREGS  = 16,
  parameter  int NRD    = 3,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREGS-1:0]       clr,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_addr,
  input  logic [NRD-1:0][AW-1:0] ra,
  output logic [NREGS-1:0]       pending,
  output logic [NRD-1:0]         busy
);

  logic [NREGS-2:0] pend_q;

  // A new producer issuing into a retiring register supersedes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NREGS - 1; i++) begin
        if (issue_valid && issue_addr == AW'(i))
          pend_q[i] <= 1'b1;
        else if (clr[i])
          pend_q[i] <= 1'b0;
      end
    end
  end

  assign pending = {1'b0, pend_q};

  always_comb begin
    busy = '0;
    for (int n = 0; n < NRD; n++)
      busy[n] = pending[ra[n]] & ~((BYPASS != 0) & clr[ra[n]]);
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two write ports
// (port 1 wins on collision), optional write-to-read bypass, PC read-through.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH  = WIDTH_DEF,
  parameter  int NREGS  = NREGS_DEF,
  parameter  int NRD    = 3,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input logic     clk,
  input logic     reset,
  regfile_if.slave bus
);

  localparam int PC = PC_IDX(NREGS);

  logic [NREGS-2:0][WIDTH-1:0] regs;
  logic [NREGS-1:0]            wr_hit;
  logic [NRD-1:0][WIDTH-1:0]   rd_mux;

  // NOTE: combinational blocks use blocking assignments and give every
  // output a default first, so no path through the block infers a latch.
  always_comb begin
    wr_hit = '0;
    for (int k = 0; k < 2; k++)
      if (bus.we[k]) wr_hit[bus.wa[k]] = 1'b1;
    wr_hit[PC] = 1'b0;
  end

  // NOTE: the storage is small and architecturally visible, so every entry
  // is cleared by reset; a large RAM would not be reset this way.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else begin
      // Port 1 is evaluated last, so its data wins an address collision.
      for (int i = 0; i < NREGS - 1; i++)
        for (int k = 0; k < 2; k++)
          if (bus.we[k] && bus.wa[k] == AW'(i)) regs[i] <= bus.wd[k];
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int n = 0; n < NRD; n++) begin
      for (int i = 0; i < NREGS - 1; i++)
        if (bus.ra[n] == AW'(i)) rd_mux[n] = regs[i];
      if (BYPASS != 0)
        for (int k = 0; k < 2; k++)
          if (bus.we[k] && bus.wa[k] == bus.ra[n]) rd_mux[n] = bus.wd[k];
      if (bus.ra[n] == AW'(PC)) rd_mux[n] = bus.pc;
    end
  end

  assign bus.rd = rd_mux;

  regfile_sb #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .BYPASS(BYPASS)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .clr        (wr_hit),
    .issue_valid(bus.issue_valid),
    .issue_addr (bus.issue_addr),
    .ra         (bus.ra),
    .pending    (bus.pending),
    .busy       (bus.busy)
  );

endmodule
